// File: rtl/pipe_skid_reg.sv
// Two-entry elastic register (main + skid) with a registered in_ready and single-cycle flush.
// out_data comes straight from the main register. The skid entry only absorbs the item
// accepted while the consumer stalls.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // State is {skid_valid, main_valid}; 2'b10 is unreachable.
  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StOne   = 2'b01;
  localparam logic [1:0] StFull  = 2'b11;

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic             xfer_in, xfer_out;
  logic [1:0]       state;

  assign state    = {skid_valid_q, main_valid_q};
  assign xfer_in  = in_valid && in_ready_q;
  assign xfer_out = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      // Data registers are kept; only the valid bits die.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case (state)
        StEmpty: begin
          if (xfer_in) begin
            main_data_d  = in_data;
            main_valid_d = 1'b1;
          end
        end
        StOne: begin
          if (xfer_in && xfer_out) begin
            main_data_d = in_data;
          end else if (xfer_in) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
          end else if (xfer_out) begin
            main_valid_d = 1'b0;
          end
        end
        StFull: begin
          if (xfer_out) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Separate flop so in_ready has no logic between register and port.
  assign in_ready_d = !skid_valid_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule
